score_counter: RTL

Tetris score accumulator that turns line-clear events from the playfield logic into the four packed-BCD score digits and a speed level. Its outputs feed the gravity tick generator, which takes the same four digits, and the seven-segment display driver. The block accepts one clear event at a time through a valid/ready handshake. It adds the awarded points one unit per cycle with BCD carry, saturates at 9999, and reports level changes.

---
 rtl/score_counter_if.sv | 9 +
 rtl/score_counter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/score_counter_if.sv
// rtl/score_counter_if.sv - clear-event handshake between playfield logic and score counter
interface score_counter_if;
  logic       clear_valid;
  logic [2:0] clear_lines;
  logic       clear_ready;

  modport master (output clear_valid, output clear_lines, input clear_ready);
  modport slave  (input clear_valid, input clear_lines, output clear_ready);
endinterface

// File: rtl/score_counter.sv
// rtl/score_counter.sv - BCD score accumulator with saturation and speed level
module score_counter #(
  parameter logic [3:0] POINTS_1 = 4'd1,
  parameter logic [3:0] POINTS_2 = 4'd3,
  parameter logic [3:0] POINTS_3 = 4'd5,
  parameter logic [3:0] POINTS_4 = 4'd8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pause,
  score_counter_if.slave      clear,
  output logic [3:0]          score1,
  output logic [3:0]          score2,
  output logic [3:0]          score3,
  output logic [3:0]          score4,
  output logic [2:0]          level,
  output logic                level_up,
  output logic                busy,
  output logic                saturated
);
  typedef enum logic {IDLE, ADD} state_t;

  state_t          state, state_d;
  logic [3:0]      pending, pending_d;
  logic [3:0][3:0] digits, digits_d, digits_inc;
  logic            saturated_d;
  logic            carry;
  logic            at_max;
  logic [2:0]      level_calc;
  logic [3:0]      points;
  logic            lines_ok;

  assign score1 = digits[0];
  assign score2 = digits[1];
  assign score3 = digits[2];
  assign score4 = digits[3];
  assign busy   = (state == ADD);
  assign at_max = (digits == 16'h9999);

  always_comb begin
    points   = 4'd0;
    lines_ok = 1'b1;
    case (clear.clear_lines)
      3'd1:    points = POINTS_1;
      3'd2:    points = POINTS_2;
      3'd3:    points = POINTS_3;
      3'd4:    points = POINTS_4;
      default: lines_ok = 1'b0;
    endcase
  end

  // Ripple increment: a digit at 9 wraps to 0 and passes the carry upward
  always_comb begin
    digits_inc = digits;
    carry      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (digits[i] == 4'd9) begin
          digits_inc[i] = 4'd0;
        end else begin
          digits_inc[i] = digits[i] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
  end

  always_comb begin
    if (digits[3] != 4'd0 || digits[2] != 4'd0 || digits[1] >= 4'd5)
      level_calc = 3'd5;
    else
      level_calc = digits[1][2:0];
  end

  always_comb begin
    clear.clear_ready = (state == IDLE) && !pause;
    state_d           = state;
    pending_d         = pending;
    digits_d          = digits;
    saturated_d       = saturated;
    if (!pause) begin
      case (state)
        IDLE: begin
          // Out-of-range line counts and post-saturation events are taken but ignored
          if (clear.clear_valid && lines_ok && !saturated) begin
            pending_d = points;
            state_d   = ADD;
          end
        end
        ADD: begin
          if (at_max) begin
            saturated_d = 1'b1;
            pending_d   = 4'd0;
            state_d     = IDLE;
          end else begin
            digits_d  = digits_inc;
            pending_d = pending - 4'd1;
            if (pending <= 4'd1)
              state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= 4'd0;
      digits    <= '0;
      saturated <= 1'b0;
      level     <= 3'd0;
      level_up  <= 1'b0;
    end else begin
      state     <= state_d;
      pending   <= pending_d;
      digits    <= digits_d;
      saturated <= saturated_d;
      if (pause) begin
        level_up <= 1'b0;
      end else begin
        level    <= level_calc;
        level_up <= (level_calc > level);
      end
    end
  end
endmodule
